// File: rtl/rx_bit_sampler_pkg.sv
// Shared UART receive definitions: the one-hot receiver states, the enable
// levels and the oversample ratio.
package rx_bit_sampler_pkg;

  typedef enum logic [4:0] {
    INTERVAL  = 5'b00001,
    STARTBIT  = 5'b00010,
    DATABITS  = 5'b00100,
    PARITYBIT = 5'b01000,
    STOPBIT   = 5'b10000
  } rx_state_e;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int OVERSAMPLE = 16;
  localparam int CNT_W      = $clog2(OVERSAMPLE);

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/rx_bit_sampler_sync.sv
// rx_sync_filter: metastability synchroniser for the raw rx line, plus the
// previous-sample register used for falling-edge (start) detection.
module rx_sync_filter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  input  logic sample_en,
  output logic rx_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // The chain runs every clk; only the edge history follows the acq strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      if (sample_en) prev_q <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~rx_s;

endmodule

// File: rtl/rx_bit_sampler.sv
// UART receive oversampling front end: start-edge detect, 3-sample majority
// vote per bit, LSB-first byte assembly with parity and framing checks.
module rx_bit_sampler
  import rx_bit_sampler_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_MID  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       acq_sig_i,
  input  logic       parity_enable_i,
  input  logic       parity_odd_i,
  input  logic [4:0] state_i,
  output logic       rx_synch_o,
  output logic       bit_synch_o,
  output logic       bit_value_o,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o
);

  localparam logic [CNT_W-1:0] VOTE_LO  = CNT_W'(SAMPLE_MID - 1);
  localparam logic [CNT_W-1:0] VOTE_MID = CNT_W'(SAMPLE_MID);
  localparam logic [CNT_W-1:0] VOTE_HI  = CNT_W'(SAMPLE_MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic             rx_s, fall;
  logic             st_start, st_data, st_par, st_stop, in_frame;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       votes_q;
  logic [7:0]       shift_q;
  logic             par_q, start_bad_q;
  logic             bit_now, bit_done;

  rx_sync_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .sample_en (acq_sig_i),
    .rx_s      (rx_s),
    .fall      (fall)
  );

  // Anything other than a single legal frame state behaves as INTERVAL.
  assign st_start = (state_i == STARTBIT);
  assign st_data  = (state_i == DATABITS);
  assign st_par   = (state_i == PARITYBIT);
  assign st_stop  = (state_i == STOPBIT);
  assign in_frame = st_start | st_data | st_par | st_stop;

  assign bit_now  = maj3(votes_q);
  assign bit_done = acq_sig_i & in_frame & (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      votes_q     <= '0;
      rx_synch_o  <= 1'b0;
      bit_synch_o <= 1'b0;
      bit_value_o <= 1'b0;
    end else begin
      rx_synch_o  <= 1'b0;
      bit_synch_o <= 1'b0;
      if (acq_sig_i) begin
        if (!in_frame) begin
          cnt_q <= '0;
          if (fall) rx_synch_o <= 1'b1;
        end else begin
          // Free-running through state changes; wraps 15->0 on its own.
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == VOTE_LO)  votes_q[0] <= rx_s;
          if (cnt_q == VOTE_MID) votes_q[1] <= rx_s;
          if (cnt_q == VOTE_HI)  votes_q[2] <= rx_s;
          if (cnt_q == CNT_LAST) begin
            bit_synch_o <= 1'b1;
            bit_value_o <= bit_now;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q      <= '0;
      par_q        <= 1'b0;
      start_bad_q  <= 1'b0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      byte_valid_o <= 1'b0;
      if (bit_done) begin
        if (st_start) begin
          shift_q     <= '0;
          par_q       <= 1'b0;
          start_bad_q <= bit_now;
        end
        if (st_data) begin
          shift_q <= {bit_now, shift_q[7:1]};
          par_q   <= par_q ^ bit_now;
        end
        if (st_par) par_q <= par_q ^ bit_now;
        if (st_stop) begin
          byte_o       <= shift_q;
          byte_valid_o <= 1'b1;
          parity_err_o <= parity_enable_i & (par_q != parity_odd_i);
          frame_err_o  <= ~bit_now | start_bad_q;
          start_bad_q  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Directed bench for rx_bit_sampler with a small receive state machine model.
`timescale 1ns/1ps
module tb_rx_bit_sampler;
  import rx_bit_sampler_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_i = 1'b1;
  logic       acq_sig_i = 1'b0;
  logic       parity_enable_i = 1'b0;
  logic       parity_odd_i = 1'b0;
  logic [4:0] state_i;
  logic       rx_synch_o, bit_synch_o, bit_value_o, byte_valid_o;
  logic       parity_err_o, frame_err_o;
  logic [7:0] byte_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rxs_n = 0;
  int bs_n = 0;
  int bv_n = 0;
  int bs_t[$];
  int phase = 0;
  int model_nb = 0;
  logic acq_mode = 1'b0;

  always #5 clk = ~clk;

  rx_bit_sampler #(.SYNC_STAGES(2), .SAMPLE_MID(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_i            (rx_i),
    .acq_sig_i       (acq_sig_i),
    .parity_enable_i (parity_enable_i),
    .parity_odd_i    (parity_odd_i),
    .state_i         (state_i),
    .rx_synch_o      (rx_synch_o),
    .bit_synch_o     (bit_synch_o),
    .bit_value_o     (bit_value_o),
    .byte_o          (byte_o),
    .byte_valid_o    (byte_valid_o),
    .parity_err_o    (parity_err_o),
    .frame_err_o     (frame_err_o)
  );

  // acq strobe: every 4th clk, or every clk when acq_mode is set
  always @(negedge clk) begin
    acq_sig_i = acq_mode | (phase == 3);
    phase = (phase + 1) % 4;
  end

  always @(negedge clk) begin
    cyc++;
    if (rx_synch_o) rxs_n++;
    if (byte_valid_o) bv_n++;
    if (bit_synch_o) begin
      bs_n++;
      bs_t.push_back(cyc);
    end
  end

  // receive state machine model: advances the clk after each strobe
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_i  <= INTERVAL;
      model_nb <= 0;
    end else if (rx_synch_o) begin
      state_i <= STARTBIT;
    end else if (bit_synch_o) begin
      case (state_i)
        STARTBIT: begin state_i <= DATABITS; model_nb <= 0; end
        DATABITS: begin
          model_nb <= model_nb + 1;
          if (model_nb == 7) state_i <= parity_enable_i ? PARITYBIT : STOPBIT;
        end
        PARITYBIT: state_i <= STOPBIT;
        default:   state_i <= INTERVAL;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_strobe();
    do @(posedge clk); while (acq_sig_i !== 1'b1);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input int n);
    rx_i = v;
    repeat (n) wait_strobe();
  endtask

  // one bit = 16 strobes; sample index g (if 0..15) is driven inverted
  task automatic send_bit(input logic v, input int g);
    for (int j = 0; j < 16; j++) begin
      rx_i = (j == g) ? ~v : v;
      wait_strobe();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stopv, input int gbit);
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == gbit) ? 9 : -1);
    if (pen) send_bit(pbit, -1);
    send_bit(stopv, -1);
  endtask

  function automatic int gap_errors(input int from, input int to, input int gap);
    int e = 0;
    for (int i = from + 1; i < to; i++)
      if (bs_t[i] - bs_t[i-1] != gap) e++;
    return e;
  endfunction

  initial begin
    int n_rx, n_bs, n_bv;
    logic [5:0] outs;

    // reset state
    repeat (3) @(negedge clk);
    outs = {rx_synch_o, bit_synch_o, bit_value_o, byte_valid_o, parity_err_o, frame_err_o};
    check("reset_flags", outs, 6'd0);
    check("reset_byte", byte_o, 8'h00);
    rst = 1'b1;
    drive(1'b1, 4);

    // 0xA5, parity off, acq every 4 clk
    n_rx = rxs_n; n_bs = bs_n; n_bv = bv_n;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 4);
    check("a5_rx_synch_cnt", rxs_n - n_rx, 1);
    check("a5_bit_synch_cnt", bs_n - n_bs, 10);
    check("a5_bit_gap_64", gap_errors(n_bs, bs_n, 64), 0);
    check("a5_byte_valid_cnt", bv_n - n_bv, 1);
    check("a5_byte", byte_o, 8'hA5);
    check("a5_parity_err", parity_err_o, 1'b0);
    check("a5_frame_err", frame_err_o, 1'b0);
    check("a5_bit_value_hold", bit_value_o, 1'b1);

    // reset asserted mid-frame, in DATABITS
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    send_bit(1'b0, -1);
    rst = 1'b0;
    #1;
    outs = {rx_synch_o, bit_synch_o, bit_value_o, byte_valid_o, parity_err_o, frame_err_o};
    check("midreset_flags", outs, 6'd0);
    check("midreset_byte", byte_o, 8'h00);
    rx_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // idle high for 100 bit times
    n_rx = rxs_n; n_bs = bs_n; n_bv = bv_n;
    drive(1'b1, 1600);
    check("idle_rx_synch", rxs_n - n_rx, 0);
    check("idle_bit_synch", bs_n - n_bs, 0);
    check("idle_byte_valid", bv_n - n_bv, 0);

    // 0x03 with odd parity: good then bad parity bit
    parity_enable_i = 1'b1; parity_odd_i = 1'b1;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, -1);
    drive(1'b1, 4);
    check("par_ok_byte", byte_o, 8'h03);
    check("par_ok_perr", parity_err_o, 1'b0);
    check("par_ok_ferr", frame_err_o, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, -1);
    drive(1'b1, 4);
    check("par_bad_byte", byte_o, 8'h03);
    check("par_bad_perr", parity_err_o, 1'b1);
    parity_enable_i = 1'b0; parity_odd_i = 1'b0;

    // single low sample at the middle vote of data bit 3
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 3);
    drive(1'b1, 4);
    check("glitch_byte", byte_o, 8'hFF);
    check("glitch_ferr", frame_err_o, 1'b0);

    // stop bit 0, then line held low (break)
    n_rx = rxs_n; n_bv = bv_n;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
    drive(1'b0, 48);
    check("break_byte", byte_o, 8'h55);
    check("break_ferr", frame_err_o, 1'b1);
    check("break_byte_valid_cnt", bv_n - n_bv, 1);
    check("break_no_retrigger", rxs_n - n_rx, 1);
    drive(1'b1, 4);
    check("break_rise_no_synch", rxs_n - n_rx, 1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 4);
    check("after_break_synch", rxs_n - n_rx, 2);
    check("after_break_byte", byte_o, 8'h3C);
    check("after_break_ferr", frame_err_o, 1'b0);

    // false start: 3-sample low pulse at idle
    n_rx = rxs_n; n_bv = bv_n;
    drive(1'b0, 3);
    drive(1'b1, 176);
    check("false_start_synch", rxs_n - n_rx, 1);
    check("false_start_valid", bv_n - n_bv, 1);
    check("false_start_byte", byte_o, 8'hFF);
    check("false_start_ferr", frame_err_o, 1'b1);
    check("false_start_perr", parity_err_o, 1'b0);

    // acq stuck high, 0x96 with even parity
    acq_mode = 1'b1;
    parity_enable_i = 1'b1; parity_odd_i = 1'b0;
    n_bs = bs_n; n_bv = bv_n;
    send_frame(8'h96, 1'b1, 1'b0, 1'b1, -1);
    drive(1'b1, 24);
    check("fast_bit_synch_cnt", bs_n - n_bs, 11);
    check("fast_bit_gap_16", gap_errors(n_bs, bs_n, 16), 0);
    check("fast_byte_valid", bv_n - n_bv, 1);
    check("fast_byte", byte_o, 8'h96);
    check("fast_perr", parity_err_o, 1'b0);
    check("fast_ferr", frame_err_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_bit_sampler.md
Name: rx_bit_sampler

Overview:
- Oversampling front end of the UART receive core; sits directly upstream of the receive state machine.
- Synchronises the raw rx line and detects the start edge. Majority-votes each bit at 16x baud and emits the rx_synch/bit_synch strobes that advance the state machine.
- Assembles the received byte (LSB first), checks parity and stop bit, and presents the byte with error flags.
- Follows the one-hot state (INTERVAL/STARTBIT/DATABITS/PARITYBIT/STOPBIT) returned by the state machine.

Parameters:
SYNC_STAGES, 2, flops in the rx input synchroniser (min 2)
SAMPLE_MID, 8, middle oversample index; votes are taken at SAMPLE_MID-1, SAMPLE_MID, SAMPLE_MID+1 (range 1..14)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
rx_i  input  1  raw serial line, idle high
acq_sig_i  input  1  one-clk strobe at 16x baudrate, from the baudrate generator
parity_enable_i  input  1  1 = parity bit present
parity_odd_i  input  1  1 = odd parity, 0 = even parity
state_i  input  5  one-hot state from the receive state machine
rx_synch_o  output  1  one-clk pulse on a detected start edge
bit_synch_o  output  1  one-clk pulse when the current bit's 16 samples are complete
bit_value_o  output  1  majority value of the bit just completed; valid with bit_synch_o
byte_o  output  8  last received byte
byte_valid_o  output  1  one-clk pulse: byte_o and error flags updated
parity_err_o  output  1  parity mismatch for byte_o (0 when parity disabled)
frame_err_o  output  1  stop bit sampled 0, or start bit voted 1, for byte_o

Behaviour:
- Reset (async, rst=0): synchroniser flops and previous-sample register = 1. Sample counter, shift register, parity accumulator = 0. All outputs = 0.
- All sampling logic advances only on clk cycles with acq_sig_i=1. Strobe outputs are registered: they assert the clk cycle after the qualifying acq strobe, for exactly one cycle.
- Start detect, state_i==INTERVAL, on each acq strobe:
  - prev <= synced rx.
  - If prev==1 and synced rx==0: rx_synch_o pulses and sample counter <= 0.
  - A line held low (break) never retriggers until a 1 has been sampled.
- Bit timing, state_i != INTERVAL:
  - 4-bit sample counter increments on each acq strobe and wraps 15->0.
  - At counts SAMPLE_MID-1..SAMPLE_MID+1, capture the synced rx into 3 vote flops.
  - On the strobe where the count is 15: bit_synch_o pulses and bit_value_o = majority(3 votes). bit_value_o holds until the next bit_synch_o.
- Per state, at bit_synch_o:
  - STARTBIT: clear the shift register and parity accumulator. A vote of 1 sets the internal start_bad flag; no abort, the frame continues.
  - DATABITS: shift right, new bit into bit 7; parity_acc ^= bit.
  - PARITYBIT: parity_acc ^= bit.
  - STOPBIT:
    - byte_o <= shift register, byte_valid_o pulses.
    - parity_err_o <= parity_enable_i & (parity_acc != parity_odd_i).
    - frame_err_o <= (bit==0) | start_bad.
    - Clear start_bad.
- Flags hold until the next byte_valid_o.
- Counter behaviour vs. the state machine: the state machine changes state the cycle after bit_synch_o. The sample counter keeps free-running on strobes through that change; no resynchronisation mid-frame.
- On return to INTERVAL, the counter is held at 0. A new edge can be detected on the first strobe in INTERVAL.
- Illegal or multi-hot state_i is treated as INTERVAL: no shifting, counter held.
- acq_sig_i stuck high: one sample per clk. Behaviour is identical with 16 clk per bit.

Decomposition:
- Shared UART package holds the one-hot state constants (INTERVAL=5'b00001, STARTBIT=5'b00010, DATABITS=5'b00100, PARITYBIT=5'b01000, STOPBIT=5'b10000), ENABLE/DISABLE, and the oversample ratio 16.
- One natural sub-module: rx_sync_filter, an SYNC_STAGES-deep synchroniser plus prev-sample/falling-edge detect.

Test Plan:
- Reset values: rst low mid-frame (during DATABITS) -> all outputs 0 next cycle. After release, with the line idle high and the state machine at INTERVAL, there are no strobes for 100 bit times.
- Byte 0xA5, parity off, acq every 4 clk, bench state machine model -> rx_synch_o once. bit_synch_o 10 times, 64 clk apart. byte_o=0xA5, byte_valid_o pulse, parity_err_o=0, frame_err_o=0.
- 0x03, odd parity: parity bit 1 -> parity_err_o=0. Parity bit 0 -> parity_err_o=1, byte_o=0x03.
- Glitch: a single low sample at vote index SAMPLE_MID in data bit 3 of 0xFF -> majority keeps 1, byte_o=0xFF.
- Stop bit driven 0 for 0x55 -> frame_err_o=1, byte_o=0x55. Line held low afterwards -> no rx_synch_o until the line returns high and falls again.
- False start: 3-sample low pulse at idle -> start vote 1 -> frame completes with frame_err_o=1.
